// File: rtl/memblk_pkg.sv
// Shared types and default sizing for the translating multi-port line memory.
// The struct field widths follow the default constants below.
package memblk_pkg;

    localparam int NPORT_DEF = 4;
    localparam int VAW_DEF   = 33;
    localparam int PGB_DEF   = 6;
    localparam int PAW_DEF   = 12;
    localparam int DW_DEF    = 528;
    localparam int NTLB_DEF  = 4;
    localparam int LAT_DEF   = 4;

    localparam int VPN_W = VAW_DEF - PGB_DEF;
    localparam int PPN_W = PAW_DEF - PGB_DEF;

    typedef struct packed {
        logic             valid;
        logic [VPN_W-1:0] vpn;
        logic [PPN_W-1:0] ppn;
    } tlb_entry_t;

    // Untranslated request held in S0/S1
    typedef struct packed {
        logic               valid;
        logic               we;
        logic [VAW_DEF-1:0] addr;
        logic [DW_DEF-1:0]  wdata;
    } req_t;

    // Translated request carried from S2 to the commit stage
    typedef struct packed {
        logic               valid;
        logic               we;
        logic               fault;
        logic [PAW_DEF-1:0] pa;
        logic [DW_DEF-1:0]  wdata;
    } stage_t;

endpackage

// File: rtl/memblk_tlb.sv
// Fully-associative TLB: one registered fill port, NPORT combinational lookups.
// A fill becomes visible to lookups on the cycle after the strobe.
module memblk_tlb
    import memblk_pkg::*;
#(
    parameter int NPORT = NPORT_DEF,
    parameter int NTLB  = NTLB_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          fill_we,
    input  logic [$clog2(NTLB)-1:0]       fill_idx,
    input  tlb_entry_t                    fill_entry,
    input  logic [NPORT-1:0][VPN_W-1:0]   look_vpn,
    output logic [NPORT-1:0]              look_hit,
    output logic [NPORT-1:0][PPN_W-1:0]   look_ppn
);

    tlb_entry_t ent_q [NTLB];
    tlb_entry_t ent_d [NTLB];

    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        ent_d = ent_q;
        if (fill_we) begin
            ent_d[fill_idx] = fill_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NTLB; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            ent_q <= ent_d;
        end
    end

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        look_hit = '0;
        look_ppn = '0;
        for (int p = 0; p < NPORT; p++) begin
            for (int i = NTLB - 1; i >= 0; i--) begin
                if (ent_q[i].valid && ent_q[i].vpn == look_vpn[p]) begin
                    look_hit[p] = 1'b1;
                    look_ppn[p] = ent_q[i].ppn;
                end
            end
        end
    end

endmodule

// File: rtl/memblk_xlat.sv
// Multi-port line memory with shared TLB translation, fixed-latency pipeline,
// read-after-write stall and write-first same-cycle commit arbitration.
module memblk_xlat
    import memblk_pkg::*;
#(
    parameter int NPORT = NPORT_DEF,
    parameter int VAW   = VAW_DEF,
    parameter int PGB   = PGB_DEF,
    parameter int PAW   = PAW_DEF,
    parameter int DW    = DW_DEF,
    parameter int NTLB  = NTLB_DEF,
    parameter int LAT   = LAT_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NPORT-1:0]             req_valid,
    output logic [NPORT-1:0]             req_ready,
    input  logic [NPORT-1:0]             req_we,
    input  logic [NPORT-1:0][VAW-1:0]    req_addr,
    input  logic [NPORT-1:0][DW-1:0]     req_wdata,
    output logic [NPORT-1:0]             resp_valid,
    output logic [NPORT-1:0]             resp_fault,
    output logic [NPORT-1:0][DW-1:0]     resp_rdata,
    input  logic                         tlb_we,
    input  logic [$clog2(NTLB)-1:0]      tlb_idx,
    input  logic                         tlb_valid,
    input  logic [VAW-PGB-1:0]           tlb_vpn,
    input  logic [PAW-PGB-1:0]           tlb_ppn,
    output logic                         stall
);

    localparam int NT = LAT - 2;  // translated stages S2..S(LAT-1)

    req_t   s0_q [NPORT];
    req_t   s0_d [NPORT];
    req_t   s1_q [NPORT];
    req_t   s1_d [NPORT];
    stage_t st_q [NT][NPORT];
    stage_t st_d [NT][NPORT];
    stage_t xl   [NPORT];
    stage_t cm   [NPORT];

    logic [NPORT-1:0]              hit;
    logic [NPORT-1:0][PPN_W-1:0]   hit_ppn;
    logic [NPORT-1:0][VPN_W-1:0]   look_vpn;
    tlb_entry_t                    fill;
    logic                          stall_c;

    logic [DW-1:0] line_mem [2**PAW];

    assign fill = '{valid: tlb_valid, vpn: tlb_vpn, ppn: tlb_ppn};

    memblk_tlb #(
        .NPORT(NPORT),
        .NTLB (NTLB)
    ) u_tlb (
        .clk       (clk),
        .rst       (rst),
        .fill_we   (tlb_we),
        .fill_idx  (tlb_idx),
        .fill_entry(fill),
        .look_vpn  (look_vpn),
        .look_hit  (hit),
        .look_ppn  (hit_ppn)
    );

    always_comb begin
        for (int p = 0; p < NPORT; p++) begin
            look_vpn[p] = s1_q[p].addr[VAW-1:PGB];
        end
    end

    // A miss travels as a no-op with pa forced to zero.
    always_comb begin
        for (int p = 0; p < NPORT; p++) begin
            xl[p].valid = s1_q[p].valid;
            xl[p].we    = s1_q[p].we;
            xl[p].fault = !hit[p];
            xl[p].pa    = hit[p] ? {hit_ppn[p], s1_q[p].addr[PGB-1:0]} : '0;
            xl[p].wdata = s1_q[p].wdata;
        end
    end

    always_comb begin
        stall_c = 1'b0;
        for (int p = 0; p < NPORT; p++) begin
            if (s1_q[p].valid && !s1_q[p].we && hit[p]) begin
                for (int s = 0; s < NT; s++) begin
                    for (int q = 0; q < NPORT; q++) begin
                        if (st_q[s][q].valid && st_q[s][q].we && !st_q[s][q].fault &&
                            st_q[s][q].pa == xl[p].pa) begin
                            stall_c = 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign stall     = stall_c;
    assign req_ready = {NPORT{!stall_c && !rst}};

    always_comb begin
        s0_d = s0_q;
        s1_d = s1_q;
        if (!stall_c) begin
            s1_d = s0_q;
            for (int p = 0; p < NPORT; p++) begin
                s0_d[p].valid = req_valid[p];
                s0_d[p].we    = req_we[p];
                s0_d[p].addr  = req_addr[p];
                s0_d[p].wdata = req_wdata[p];
            end
        end
        for (int p = 0; p < NPORT; p++) begin
            st_d[0][p] = stall_c ? '0 : xl[p];
        end
        for (int s = 1; s < NT; s++) begin
            st_d[s] = st_q[s-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NPORT; p++) begin
                s0_q[p] <= '0;
                s1_q[p] <= '0;
                for (int s = 0; s < NT; s++) begin
                    st_q[s][p] <= '0;
                end
            end
        end else begin
            s0_q <= s0_d;
            s1_q <= s1_d;
            st_q <= st_d;
        end
    end

    assign cm = st_q[NT-1];

    // NOTE: the line array has no reset; its contents are undefined until written.
    // Ascending port order makes the highest port the last write to the same line.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NPORT; p++) begin
            if (cm[p].valid && cm[p].we && !cm[p].fault) begin
                line_mem[cm[p].pa] <= cm[p].wdata;
            end
        end
    end

    // Reads at commit see same-cycle writes to their line (write-first).
    always_comb begin
        resp_valid = '0;
        resp_fault = '0;
        resp_rdata = '0;
        for (int p = 0; p < NPORT; p++) begin
            resp_valid[p] = cm[p].valid;
            resp_fault[p] = cm[p].valid && cm[p].fault;
            if (cm[p].valid && !cm[p].we && !cm[p].fault) begin
                resp_rdata[p] = line_mem[cm[p].pa];
                for (int q = 0; q < NPORT; q++) begin
                    if (cm[q].valid && cm[q].we && !cm[q].fault && cm[q].pa == cm[p].pa) begin
                        resp_rdata[p] = cm[q].wdata;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_memblk_xlat.sv
// Directed bench for memblk_xlat: translation, faults, hazard stall, commit
// collision, TLB fill race, multi-hit priority and mid-flight reset.
module tb_memblk_xlat;

    localparam int NPORT = 4;
    localparam int VAW   = 33;
    localparam int PGB   = 6;
    localparam int PAW   = 12;
    localparam int DW    = 528;
    localparam int NTLB  = 4;
    localparam int LAT   = 4;

    localparam logic [DW-1:0] DA = {66{8'hA1}};
    localparam logic [DW-1:0] DB = {66{8'hB2}};
    localparam logic [DW-1:0] DC = {66{8'hC3}};
    localparam logic [DW-1:0] DD = {66{8'hD4}};
    localparam logic [DW-1:0] DZ = {66{8'h5A}};
    localparam logic [DW-1:0] XA = {66{8'hAA}};
    localparam logic [DW-1:0] XB = {66{8'hBB}};

    logic                       clk;
    logic                       rst;
    logic [NPORT-1:0]           req_valid;
    logic [NPORT-1:0]           req_ready;
    logic [NPORT-1:0]           req_we;
    logic [NPORT-1:0][VAW-1:0]  req_addr;
    logic [NPORT-1:0][DW-1:0]   req_wdata;
    logic [NPORT-1:0]           resp_valid;
    logic [NPORT-1:0]           resp_fault;
    logic [NPORT-1:0][DW-1:0]   resp_rdata;
    logic                       tlb_we;
    logic [$clog2(NTLB)-1:0]    tlb_idx;
    logic                       tlb_valid;
    logic [VAW-PGB-1:0]         tlb_vpn;
    logic [PAW-PGB-1:0]         tlb_ppn;
    logic                       stall;

    memblk_xlat #(
        .NPORT(NPORT), .VAW(VAW), .PGB(PGB), .PAW(PAW),
        .DW(DW), .NTLB(NTLB), .LAT(LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_fault(resp_fault),
        .resp_rdata(resp_rdata),
        .tlb_we    (tlb_we),
        .tlb_idx   (tlb_idx),
        .tlb_valid (tlb_valid),
        .tlb_vpn   (tlb_vpn),
        .tlb_ppn   (tlb_ppn),
        .stall     (stall)
    );

    typedef struct {
        int            cyc;
        logic          fault;
        logic [DW-1:0] rd;
    } resp_t;

    resp_t rq [NPORT][$];
    int    cyc = 0;
    int    n_vec = 0;
    int    n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Response log, sampled mid-cycle; cyc is the number of rising edges so far.
    always @(negedge clk) begin
        for (int p = 0; p < NPORT; p++) begin
            if (resp_valid[p]) begin
                resp_t r;
                r.cyc   = cyc;
                r.fault = resp_fault[p];
                r.rd    = resp_rdata[p];
                rq[p].push_back(r);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int p, input logic we, input logic [VAW-1:0] a, input logic [DW-1:0] d);
        req_valid[p] = 1'b1;
        req_we[p]    = we;
        req_addr[p]  = a;
        req_wdata[p] = d;
    endtask

    // Presents the staged requests for one edge; acc is the accepting edge number.
    task automatic step(output int acc);
        logic [NPORT-1:0] v;
        v = req_valid;
        @(negedge clk);
        check("ready", req_ready & v, v);
        @(posedge clk);
        #1;
        acc       = cyc;
        req_valid = '0;
        req_we    = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fill(input int idx, input logic v, input logic [VAW-PGB-1:0] vpn, input logic [PAW-PGB-1:0] ppn);
        tlb_idx   = idx[$clog2(NTLB)-1:0];
        tlb_valid = v;
        tlb_vpn   = vpn;
        tlb_ppn   = ppn;
        tlb_we    = 1'b1;
        @(posedge clk);
        #1;
        tlb_we    = 1'b0;
    endtask

    task automatic expect_resp(input string tag, input int p, input int acc, input int extra,
                               input logic fault, input logic [DW-1:0] rd);
        resp_t r;
        check({tag, "_present"}, DW'(rq[p].size() > 0), 1);
        if (rq[p].size() > 0) begin
            r = rq[p].pop_front();
            check({tag, "_latency"}, DW'(r.cyc - acc), DW'(LAT - 1 + extra));
            check({tag, "_fault"}, DW'(r.fault), DW'(fault));
            check({tag, "_rdata"}, r.rd, rd);
        end
    endtask

    initial begin
        int a0, a1, a2, aw, ar, r1, r2, b0, b1, b2, b3;
        int nst;

        rst       = 1'b1;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        tlb_we    = 1'b0;
        tlb_idx   = '0;
        tlb_valid = 1'b0;
        tlb_vpn   = '0;
        tlb_ppn   = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", DW'(req_ready), 0);
        check("rst_resp_valid", DW'(resp_valid), 0);
        check("rst_resp_fault", DW'(resp_fault), 0);
        check("rst_stall", DW'(stall), 0);
        check("rst_rdata0", resp_rdata[0], '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);

        // Empty TLB: everything faults
        set_req(0, 1'b0, 33'h07FFFFFFF, '0);
        set_req(1, 1'b1, 33'h1C5, DZ);
        step(a0);
        idle(6);
        expect_resp("flt_rd", 0, a0, 0, 1'b1, '0);
        expect_resp("flt_wr", 1, a0, 0, 1'b1, '0);

        // vpn1 -> ppn3, vpn2 -> ppn0
        fill(0, 1'b1, 27'h1, 6'h3);
        fill(2, 1'b1, 27'h2, 6'h0);

        set_req(0, 1'b1, 33'h045, DA);
        step(a0);
        set_req(0, 1'b1, 33'h085, DB);
        step(a1);
        idle(6);
        expect_resp("wr_a", 0, a0, 0, 1'b0, '0);
        expect_resp("wr_b", 0, a1, 0, 1'b0, '0);

        // Faulting writes must leave the array alone
        set_req(3, 1'b1, 33'h1C5, DZ);
        set_req(2, 1'b1, 33'h005, DZ);
        step(a2);
        idle(6);
        expect_resp("flt_wr3", 3, a2, 0, 1'b1, '0);
        expect_resp("flt_wr2", 2, a2, 0, 1'b1, '0);

        // Back-to-back reads on one port
        set_req(1, 1'b0, 33'h045, '0);
        step(b0);
        set_req(1, 1'b0, 33'h085, '0);
        step(b1);
        set_req(1, 1'b0, 33'h045, '0);
        step(b2);
        set_req(1, 1'b0, 33'h085, '0);
        step(b3);
        idle(6);
        expect_resp("b2b_0", 1, b0, 0, 1'b0, DA);
        expect_resp("b2b_1", 1, b1, 0, 1'b0, DB);
        expect_resp("b2b_2", 1, b2, 0, 1'b0, DA);
        expect_resp("b2b_3", 1, b3, 0, 1'b0, DB);

        // Read-after-write hazard on PA 0x0C5
        set_req(0, 1'b1, 33'h045, DC);
        step(aw);
        set_req(1, 1'b0, 33'h045, '0);
        step(ar);
        nst = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            nst += int'(stall);
            if (cyc == ar + 1) begin
                check("haz_stall_now", DW'(stall), 1);
                check("haz_ready_low", DW'(req_ready), 0);
            end
        end
        @(posedge clk);
        #1;
        check("haz_stall_cycles", DW'(nst), DW'(LAT - 2));
        idle(3);
        expect_resp("haz_wr", 0, aw, 0, 1'b0, '0);
        expect_resp("haz_rd", 1, ar, LAT - 2, 1'b0, DC);

        // Same-cycle commit collision on PA 0x010
        set_req(0, 1'b1, 33'h090, XA);
        set_req(3, 1'b1, 33'h090, XB);
        set_req(2, 1'b0, 33'h090, '0);
        step(a0);
        idle(6);
        expect_resp("col_wr0", 0, a0, 0, 1'b0, '0);
        expect_resp("col_wr3", 3, a0, 0, 1'b0, '0);
        expect_resp("col_rd2", 2, a0, 0, 1'b0, XB);
        set_req(1, 1'b0, 33'h090, '0);
        step(a1);
        idle(6);
        expect_resp("col_array", 1, a1, 0, 1'b0, XB);

        // Seed PA 0x145 through vpn5 -> ppn5
        fill(3, 1'b1, 27'h5, 6'h5);
        set_req(0, 1'b1, 33'h145, DD);
        step(a0);
        idle(6);
        expect_resp("seed_d", 0, a0, 0, 1'b0, '0);

        // Fill lands while the first read sits in S1
        set_req(0, 1'b0, 33'h045, '0);
        step(r1);
        set_req(0, 1'b0, 33'h045, '0);
        step(r2);
        fill(0, 1'b1, 27'h1, 6'h5);
        idle(6);
        expect_resp("race_old", 0, r1, 0, 1'b0, DC);
        expect_resp("race_new", 0, r2, 0, 1'b0, DD);

        // idx0 (ppn5) and idx1 (ppn3) both match vpn1
        fill(1, 1'b1, 27'h1, 6'h3);
        set_req(2, 1'b0, 33'h045, '0);
        step(a0);
        idle(6);
        expect_resp("multi_low", 2, a0, 0, 1'b0, DD);
        fill(0, 1'b0, 27'h1, 6'h5);
        set_req(2, 1'b0, 33'h045, '0);
        step(a1);
        idle(6);
        expect_resp("multi_next", 2, a1, 0, 1'b0, DC);

        // Reset with three requests in flight
        set_req(0, 1'b0, 33'h045, '0);
        set_req(1, 1'b0, 33'h045, '0);
        set_req(2, 1'b0, 33'h045, '0);
        step(a0);
        idle(1);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(8);
        check("mid_rst_p0", DW'(rq[0].size()), 0);
        check("mid_rst_p1", DW'(rq[1].size()), 0);
        check("mid_rst_p2", DW'(rq[2].size()), 0);
        check("mid_rst_stall", DW'(stall), 0);
        set_req(0, 1'b0, 33'h045, '0);
        step(a1);
        idle(6);
        expect_resp("mid_rst_tlb", 0, a1, 0, 1'b1, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/memblk_xlat.md
# memblk_xlat

Parametrised successor to the multi-port memory block. It provides NPORT independent request ports, each translating a virtual line address through a shared fully-associative TLB. Requests then pass through a fixed-depth pipeline into a physical line array. Read-after-write hazards are detected and stall intake. Each request receives a per-request response with a fault flag. It sits between the load/store port arbiters and the backing line store.

## Interface
- NPORT, 4, number of request ports
- VAW, 33, virtual line-address width
- PGB, 6, page-offset bits (line units)
- PAW, 12, physical line-address width (array depth 2^PAW); PPN width = PAW-PGB, VPN width = VAW-PGB
- DW, 528, line data width
- NTLB, 4, TLB entries
- LAT, 4, accept-to-response latency in cycles, minimum 3
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  [NPORT]  request present
- req_ready  out  [NPORT]  request accepted this cycle if valid
- req_we  in  [NPORT]  1 = write, 0 = read
- req_addr  in  [NPORT][VAW]  virtual line address
- req_wdata  in  [NPORT][DW]  write data
- resp_valid  out  [NPORT]  response pulse, one per accepted request
- resp_fault  out  [NPORT]  TLB miss; no array access performed
- resp_rdata  out  [NPORT][DW]  read data; 0 for writes and faults
- tlb_we  in  1  TLB fill strobe
- tlb_idx  in  [$clog2(NTLB)]  entry written
- tlb_valid  in  1  entry valid bit
- tlb_vpn  in  [VAW-PGB]  virtual page
- tlb_ppn  in  [PAW-PGB]  physical page
- stall  out  1  hazard stall active

## Operation
- Stage S0: request registered on an edge where req_valid && req_ready.
- Stage S1: lookup compares VPN = addr[VAW-1:PGB] against all valid entries.
  - Hit: PA = {ppn, addr[PGB-1:0]}.
  - Multiple hits: lowest index wins.
  - Miss: fault flag set; the request travels as a no-op.
- Stages S2..S(LAT-1) carry the translated request. Commit occurs at S(LAT-1): writes update the array, reads sample it.
- Hazard: stall=1 when any non-faulting read in S1 has a PA equal to any non-faulting write in S2..S(LAT-1) on any port.
  - During stall, S0/S1 hold and a bubble enters S2.
  - S2 onward always advance.
- Same-PA commits in one cycle:
  - Several writes: highest port index wins.
  - A read alongside a write returns the winning write data (write-first).
- TLB fill is visible to S1 lookups from the cycle after tlb_we. A lookup in the same cycle as a fill uses the old entry.
- Each port is in order. Responses never reorder within a port.
- Writes also get resp_valid, with rdata=0.

## Timing
- Request accepted at edge E: resp_valid is high for exactly the cycle following edge E+LAT-1, plus any stall cycles incurred while in S0/S1.
- req_ready = !stall && !rst, combinational. It is 0 during reset.
- stall is combinational from pipeline registers only. There is no path from req_valid to stall.
- Reset values:
  - resp_valid=0, resp_fault=0, resp_rdata=0, stall=0.
  - All stage valids=0.
  - All TLB valid bits=0.
  - Array contents are not reset.
- Reset mid-operation discards all in-flight requests; no responses are issued for them.
- Back-to-back: one request per port per cycle sustained when there are no hazards.

## Structure
- Package memblk_pkg holds:
  - tlb_entry_t {valid, vpn, ppn}
  - stage_t {valid, we, fault, pa, wdata}
  - default parameter constants
- Sub-module memblk_tlb: NTLB-entry register file with one fill port and NPORT combinational CAM lookup ports (hit, ppn).
- Top level holds the pipeline, hazard comparator, commit arbitration and array.

## Test plan
- Basic translation: fill idx0 {v=1, vpn=0x1, ppn=0x3}. Write addr 0x045, data A, port0. Later read 0x045 on port1 -> rdata=A, fault=0, resp exactly LAT cycles after accept. Array line 0x0C5 holds A.
- Fault: no valid entries. Read 0x7FFFFFFF -> resp_fault=1, rdata=0. Write to an unmapped address -> fault=1, array unchanged.
- Hazard stall: port0 writes PA 0x0C5, port1 reads the same PA the next cycle -> stall=1 for LAT-2 cycles, req_ready=0 on all ports, then read returns the new data.
- Commit collision: ports 0 and 3 write PA 0x010 with 0xAA.. and 0xBB.. in the same cycle, port2 reads it the same cycle -> array holds 0xBB.., port2 rdata=0xBB...
- TLB update race: fill idx0 ppn 0x3->0x5 in the same cycle a lookup of vpn 0x1 is in S1 -> that request uses 0x3, the next uses 0x5. Two entries matching vpn 0x1 -> lowest index used.
- Reset mid-flight: assert rst with 3 requests in flight -> no resp_valid after release, stall=0, TLB empty (next lookup faults).
